// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and transfer sequencer for the shared
// 32-bit datapath bus. Each cycle it picks one requester and, one cycle later,
// drives a one-hot grant together with one-hot source-select and destination
// load-enable vectors decoded from the winner's codes.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset
//   req        per-requester transfer request            [NREQ]
//   lock       per-requester bus-hold request            [NREQ]
//   src_code   packed source codes, requester i at [i*CW +: CW]
//   dst_code   packed destination codes, same packing
//   gnt        one-hot grant, high in the transfer cycle [NREQ]
//   drive_sel  one-hot source select, 1<<src of winner   [NSRC]
//   load_en    one-hot destination load, 1<<dst of winner [NSRC]
//   busy       high whenever a grant is active
//   err        one-cycle pulse when the granted src or dst code is out of range
module bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int NSRC    = 24,
  parameter int CW      = 5,
  parameter int MAXLOCK = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*CW-1:0] src_code,
  input  logic [NREQ*CW-1:0] dst_code,
  output logic [NREQ-1:0]    gnt,
  output logic [NSRC-1:0]    drive_sel,
  output logic [NSRC-1:0]    load_en,
  output logic               busy,
  output logic               err
);

  localparam int PW = $clog2(NREQ);
  localparam int LW = $clog2(MAXLOCK + 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic          owner_vld;
  logic [LW-1:0] lock_cnt;

  logic            hold;
  logic            release_lock;
  logic            any_win;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic            found;
  logic [NREQ-1:0] others;
  logic [NREQ-1:0] cand;
  logic [CW-1:0]   w_src;
  logic [CW-1:0]   w_dst;
  logic            src_ok;
  logic            dst_ok;

  always_comb begin
    hold         = owner_vld && req[owner] && lock[owner];
    others       = req;
    others[owner] = 1'b0;
    // Owner has used its full allowance and someone else is waiting:
    // skip the owner this cycle and let round-robin pick among the rest.
    release_lock = hold && (lock_cnt == LW'(MAXLOCK)) && (|others);
    any_win      = |req;
    cand         = release_lock ? others : req;
    win          = '0;
    idx          = '0;
    found        = 1'b0;
    if (hold && !release_lock) begin
      win   = owner;
      found = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = PW'((32'(ptr) + k) % 32'(NREQ));
        if (!found && cand[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    w_src  = src_code[32'(win)*CW +: CW];
    w_dst  = dst_code[32'(win)*CW +: CW];
    src_ok = 32'(w_src) < 32'(NSRC);
    dst_ok = 32'(w_dst) < 32'(NSRC);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      gnt       <= '0;
      drive_sel <= '0;
      load_en   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      ptr       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      busy      <= any_win;
      gnt       <= any_win ? (NREQ'(1) << win) : '0;
      drive_sel <= (any_win && src_ok) ? (NSRC'(1) << w_src) : '0;
      load_en   <= (any_win && dst_ok) ? (NSRC'(1) << w_dst) : '0;
      err       <= any_win && !(src_ok && dst_ok);
      if (any_win) begin
        ptr <= (32'(win) == 32'(NREQ - 1)) ? '0 : win + 1'b1;
        if (hold && !release_lock) begin
          if (lock_cnt != LW'(MAXLOCK))
            lock_cnt <= lock_cnt + 1'b1;
        end else if (lock[win]) begin
          owner     <= win;
          owner_vld <= 1'b1;
          lock_cnt  <= LW'(1);
        end else begin
          owner_vld <= 1'b0;
          lock_cnt  <= '0;
        end
      end else if (!hold) begin
        // Owner dropped its request while the bus went idle.
        owner_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [19:0] src_code;
  logic [19:0] dst_code;
  logic [3:0]  gnt;
  logic [23:0] drive_sel;
  logic [23:0] load_en;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.NREQ(4), .NSRC(24), .CW(5), .MAXLOCK(8)) dut (
    .clk(clk), .clr(clr), .req(req), .lock(lock),
    .src_code(src_code), .dst_code(dst_code),
    .gnt(gnt), .drive_sel(drive_sel), .load_en(load_en),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic [3:0]  r;
    logic [3:0]  l;
    logic [19:0] s;
    logic [19:0] d;
    logic [3:0]  g;
    logic [23:0] ds;
    logic [23:0] ld;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int e);
    return {5'(e), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [23:0] oh(input int n);
    logic [23:0] one;
    one = 24'd1;
    return one << n;
  endfunction

  task automatic apply(input logic c, input logic [3:0] r, input logic [3:0] l,
                       input logic [19:0] s, input logic [19:0] d);
    clr = c; req = r; lock = l; src_code = s; dst_code = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] g, input logic [23:0] ds,
                     input logic [23:0] ld, input logic e);
    checks++;
    if (gnt !== g) begin
      errors++; $display("FAIL %s gnt: got %b want %b", nm, gnt, g);
    end
    checks++;
    if (drive_sel !== ds) begin
      errors++; $display("FAIL %s drive_sel: got %h want %h", nm, drive_sel, ds);
    end
    checks++;
    if (load_en !== ld) begin
      errors++; $display("FAIL %s load_en: got %h want %h", nm, load_en, ld);
    end
    checks++;
    if (busy !== (|g)) begin
      errors++; $display("FAIL %s busy: got %b want %b", nm, busy, |g);
    end
    checks++;
    if (err !== e) begin
      errors++; $display("FAIL %s err: got %b want %b", nm, err, e);
    end
  endtask

  initial begin
    logic [19:0] s1, d1, sl, dl;
    clr = 1'b1; req = '0; lock = '0; src_code = '0; dst_code = '0;

    // ---------- table: reset priority, single transfer, illegal codes, idle hold
    s1 = pk(0, 1, 2, 3);
    d1 = pk(4, 5, 6, 7);
    vecs.push_back('{1'b1, 4'b1111, 4'b0, s1, d1, 4'b0000, 24'h0, 24'h0, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 4'b0, s1, d1, 4'b0000, 24'h0, 24'h0, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0, s1, d1, 4'b0001, oh(0), oh(4), 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0, s1, d1, 4'b0010, oh(1), oh(5), 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0, s1, d1, 4'b0100, oh(2), oh(6), 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0, s1, d1, 4'b1000, oh(3), oh(7), 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b0, s1, d1, 4'b0001, oh(0), oh(4), 1'b0});
    // single transfer from PC (20) into register 3; pointer now 1 -> 3 afterwards
    vecs.push_back('{1'b0, 4'b0100, 4'b0, pk(0, 0, 20, 0), pk(0, 0, 3, 0),
                     4'b0100, 24'h100000, 24'h000008, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 4'b0, '0, '0, 4'b0000, 24'h0, 24'h0, 1'b0});
    // out-of-range source; pointer 3 -> requester 1 still wins, pointer -> 2
    vecs.push_back('{1'b0, 4'b0010, 4'b0, pk(0, 25, 0, 0), pk(0, 4, 0, 0),
                     4'b0010, 24'h0, 24'h000010, 1'b1});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 4'b0000, 4'b0, '0, '0, 4'b0000, 24'h0, 24'h0, 1'b0});
    // pointer parked at 2 across the idle stretch
    vecs.push_back('{1'b0, 4'b0101, 4'b0, pk(0, 0, 2, 0), pk(1, 0, 3, 0),
                     4'b0100, oh(2), oh(3), 1'b0});
    vecs.push_back('{1'b0, 4'b0101, 4'b0, pk(0, 0, 2, 0), pk(1, 0, 3, 0),
                     4'b0001, oh(0), oh(1), 1'b0});
    vecs.push_back('{1'b0, 4'b0101, 4'b0, pk(0, 0, 2, 0), pk(1, 0, 3, 0),
                     4'b0100, oh(2), oh(3), 1'b0});
    // pointer 3: out-of-range destination
    vecs.push_back('{1'b0, 4'b1000, 4'b0, pk(0, 0, 0, 5), pk(0, 0, 0, 30),
                     4'b1000, oh(5), 24'h0, 1'b1});
    // src equal to dst is legal
    vecs.push_back('{1'b0, 4'b0001, 4'b0, pk(7, 0, 0, 0), pk(7, 0, 0, 0),
                     4'b0001, oh(7), oh(7), 1'b0});
    // clear while a request is still present
    vecs.push_back('{1'b1, 4'b0001, 4'b0, pk(7, 0, 0, 0), pk(7, 0, 0, 0),
                     4'b0000, 24'h0, 24'h0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].c, vecs[i].r, vecs[i].l, vecs[i].s, vecs[i].d);
      chk($sformatf("vec%0d", i), vecs[i].g, vecs[i].ds, vecs[i].ld, vecs[i].e);
    end

    // ---------- lock starvation limit and counter saturation
    sl = pk(0, 1, 2, 3);
    dl = pk(8, 9, 10, 11);
    apply(1'b1, 4'b0, 4'b0, sl, dl);
    chk("lk_clr", 4'b0, 24'h0, 24'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 4'b0011, 4'b0001, sl, dl);
      chk($sformatf("lk_own%0d", i), 4'b0001, oh(0), oh(8), 1'b0);
    end
    apply(1'b0, 4'b0011, 4'b0001, sl, dl);
    chk("lk_release", 4'b0010, oh(1), oh(9), 1'b0);
    apply(1'b0, 4'b0011, 4'b0001, sl, dl);
    chk("lk_regain", 4'b0001, oh(0), oh(8), 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 4'b0001, 4'b0001, sl, dl);
      chk($sformatf("lk_sat%0d", i), 4'b0001, oh(0), oh(8), 1'b0);
    end
    apply(1'b0, 4'b0011, 4'b0001, sl, dl);
    chk("lk_sat_release", 4'b0010, oh(1), oh(9), 1'b0);

    // ---------- reset in the middle of a lock held by requester 3
    apply(1'b1, 4'b0, 4'b0, sl, dl);
    chk("ml_clr", 4'b0, 24'h0, 24'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 4'b1000, 4'b1000, sl, dl);
      chk($sformatf("ml_own%0d", i), 4'b1000, oh(3), oh(11), 1'b0);
    end
    apply(1'b1, 4'b1000, 4'b1000, sl, dl);
    chk("ml_reset", 4'b0, 24'h0, 24'h0, 1'b0);
    apply(1'b0, 4'b1001, 4'b0000, sl, dl);
    chk("ml_ptr0", 4'b0001, oh(0), oh(8), 1'b0);
    apply(1'b0, 4'b1001, 4'b0000, sl, dl);
    chk("ml_next", 4'b1000, oh(3), oh(11), 1'b0);
    apply(1'b0, 4'b0000, 4'b0000, sl, dl);
    chk("ml_idle", 4'b0, 24'h0, 24'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
